slice_arbiter: RTL and testbench
================================

# slice_arbiter

Time-sliced round-robin arbiter for the tick/slow-counter prescaler datapath. The block grants one shared resource to one of N requesters at a time. While a grant is held, it runs a programmable prescaler that emits single-cycle `tick` pulses and counts them in `slice_cnt`. A grant ends on slice expiry, on an early `done` from the owner, or when the owner drops its request.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `SLICE_TICKS`, 4: prescaler periods per time slice (2..8).
- `DIV_W`, 4: width of the divide input.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `div`  in  DIV_W  prescaler period minus one (tick period = div+1 cycles). Sampled only at grant entry.
- `req`  in  N  request per requester. Level-sensitive.
- `done`  in  N  early-release pulse per requester. Only the bit of the current owner is honoured.
- `gnt`  out  N  one-hot grant (all zero when idle). Registered.
- `gnt_id`  out  $clog2(N)  index of the current or most recent owner. Registered.
- `busy`  out  1  high while in GRANT.
- `tick`  out  1  one-cycle pulse per completed prescaler period within a grant. Registered.
- `slice_cnt`  out  $clog2(SLICE_TICKS)+1  ticks delivered in the current grant.

## Operation
- The FSM has two states: IDLE and GRANT.
- Reset values:
  - State is IDLE.
  - `gnt`=0, `busy`=0, `tick`=0, `slice_cnt`=0, prescaler count=0.
  - Internal last-owner pointer is N-1, so requester 0 has first priority.
  - `gnt_id`=0.
- IDLE:
  - If `req`≠0, select the first set bit searching upward from last+1, wrapping modulo N.
  - At that edge, set `gnt[sel]`, `gnt_id`=sel, `busy`=1, and latch `div` into `div_q`. Clear the prescaler count and `slice_cnt`. Go to GRANT.
  - If `req`=0, stay in IDLE; `tick` stays 0.
- GRANT: evaluate each edge in this priority order.
  1. Release: if `done[gnt_id]`=1 or `req[gnt_id]`=0, clear `gnt`/`busy`, set last=`gnt_id`, go to IDLE. No tick is emitted at this edge.
  2. Expiry: if the prescaler count = `div_q` and `slice_cnt` = SLICE_TICKS-1, behave the same as release.
  3. Period end: if the prescaler count = `div_q`, clear the count, set `tick`<=1 and `slice_cnt`<=`slice_cnt`+1.
  4. Otherwise: increment the count and set `tick`<=0.
- After every grant, IDLE lasts at least one cycle before the next grant. There is no back-to-back regrant.
- `div` changes during a grant have no effect until the next grant. `div`=0 gives a tick every cycle.
- `done` bits of non-owners are ignored. A non-owner's `req` is never lost; it waits for the round-robin pointer to reach it.
- Arithmetic:
  - The prescaler count is DIV_W bits and never exceeds `div_q`, so it cannot wrap.
  - `slice_cnt` never exceeds SLICE_TICKS-1.
- Reset mid-grant: the next edge returns every output and pointer to its reset value, regardless of `req`/`done`.

## Timing
- Grant latency: `req` seen at edge e (in IDLE) gives `gnt` high in cycle e+1. Call that cycle G.
- Prescaler count in cycle G+c equals c mod (div_q+1).
- `tick` is high in cycles G+j·(div_q+1) for j=1..SLICE_TICKS-1. `slice_cnt`=j from that cycle onward.
- Without early release, `gnt` is high for exactly SLICE_TICKS·(div_q+1) cycles. It is low from cycle G+SLICE_TICKS·(div_q+1).
- Early release: `done` (or `req` dropped) sampled high in cycle G+k gives `gnt` low in cycle G+k+1. `tick` is 0 in that cycle.
- `gnt_id` holds its value after release until the next grant. `tick` is never high while `busy`=0.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req`=1111 → `gnt`=0, `busy`=0, `tick`=0, `slice_cnt`=0, `gnt_id`=0. The first grant after release goes to requester 0.
- **Single requester, full slice:** N=4, SLICE_TICKS=4, `div`=2, `req`=0001 held → `gnt`=0001 from G. `tick` is high at G+3, G+6, G+9 with `slice_cnt`=1,2,3. `gnt` is low at G+12 for one cycle, then requester 0 is regranted.
- **Round robin:** `req`=1111 held, `div`=0 → `gnt_id` sequence is 0,1,2,3,0. Each grant lasts 4 cycles, with one idle cycle between grants.
- **Early release and non-owner done:** owner 1 with `div`=2. `done`=0100 in cycle G+2 → ignored. `done`=0010 in cycle G+4 → `gnt`=0 at G+5 and `tick`=0. The next grant goes to requester 2 if it is requesting.
- **div change mid-grant:** `div`=2 latched at grant; `div` changed to 5 at G+1 → ticks still at G+3/6/9. The next grant uses a period of 6.
- **Reset mid-grant:** `rst` in cycle G+4 → all outputs are zero the next cycle. The pointer is reset, so requester 0 wins next.

Source files
------------

// File: rtl/slice_arbiter.sv
// Time-sliced round-robin arbiter: grants one requester at a time and runs a
// per-grant prescaler that emits ticks until slice expiry, done, or request drop.
module slice_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned SLICE_TICKS = 4,
  parameter int unsigned DIV_W       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIV_W-1:0]                 div,
  input  logic [N-1:0]                     req,
  input  logic [N-1:0]                     done,
  output logic [N-1:0]                     gnt,
  output logic [$clog2(N)-1:0]             gnt_id,
  output logic                             busy,
  output logic                             tick,
  output logic [$clog2(SLICE_TICKS):0]     slice_cnt
);

  localparam int unsigned ID_W = $clog2(N);
  localparam int unsigned SC_W = $clog2(SLICE_TICKS) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  logic [ID_W-1:0]  sel_c;
  logic             release_c;
  logic             period_end_c;
  logic             expire_c;

  // First requester strictly after the last owner, wrapping modulo N
  always_comb begin
    sel_c = last;
    for (int unsigned i = N; i >= 1; i--) begin
      if (req[(32'(last) + i) % N]) begin
        sel_c = ID_W'((32'(last) + i) % N);
      end
    end
  end

  assign release_c    = done[gnt_id] | ~req[gnt_id];
  assign period_end_c = (cnt == div_q);
  assign expire_c     = period_end_c && (slice_cnt == SC_W'(SLICE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= ID_W'(N - 1);
      cnt       <= '0;
      div_q     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      slice_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick <= 1'b0;
          if (req != '0) begin
            state     <= GRANT;
            gnt       <= N'(1) << sel_c;
            gnt_id    <= sel_c;
            busy      <= 1'b1;
            div_q     <= div;
            cnt       <= '0;
            slice_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_c || expire_c) begin
            // Release and expiry share one exit; no tick at the exit edge
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            tick  <= 1'b0;
            last  <= gnt_id;
          end else if (period_end_c) begin
            cnt       <= '0;
            tick      <= 1'b1;
            slice_cnt <= slice_cnt + SC_W'(1);
          end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_arbiter.sv
// Bench for slice_arbiter: directed vector table, hand sequences, and random
// stimulus against a cycle-count based reference model.
module tb_slice_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned ST   = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned SW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] div;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [IDW-1:0] gnt_id;
  logic          busy;
  logic          tick;
  logic [SW-1:0] slice_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  slice_arbiter #(.N(N), .SLICE_TICKS(ST), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .div(div), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .tick(tick), .slice_cnt(slice_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a grant is described by its owner, latched period and
  // the number of cycles elapsed since the grant cycle G.
  bit m_active;
  int m_id, m_last, m_per, m_elapsed, m_slice;
  bit m_tick;

  task automatic model_step(input bit r, input logic [N-1:0] rq,
                            input logic [N-1:0] dn, input logic [DW-1:0] dv);
    bit endp, expire;
    if (r) begin
      m_active = 0; m_last = N - 1; m_id = 0; m_tick = 0; m_slice = 0; m_elapsed = 0;
      m_per = 1;
    end else if (!m_active) begin
      m_tick = 0;
      if (rq != 0) begin
        for (int i = N; i >= 1; i--)
          if (rq[(m_last + i) % N]) m_id = (m_last + i) % N;
        m_active = 1; m_per = int'(dv) + 1; m_elapsed = 0; m_slice = 0;
      end
    end else begin
      endp   = ((m_elapsed + 1) % m_per) == 0;
      expire = endp && (m_elapsed / m_per == ST - 1);
      if (dn[m_id] || !rq[m_id] || expire) begin
        m_active = 0; m_last = m_id; m_tick = 0;
      end else begin
        m_elapsed++;
        m_tick  = endp;
        m_slice = m_elapsed / m_per;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input logic [N-1:0] rq,
                       input logic [N-1:0] dn, input logic [DW-1:0] dv);
    rst = r; req = rq; done = dn; div = dv;
    @(posedge clk);
    model_step(r, rq, dn, dv);
    #1;
  endtask

  task automatic chk_model();
    chk("gnt",       int'(gnt),       m_active ? (1 << m_id) : 0);
    chk("gnt_id",    int'(gnt_id),    m_id);
    chk("busy",      int'(busy),      int'(m_active));
    chk("tick",      int'(tick),      int'(m_tick));
    chk("slice_cnt", int'(slice_cnt), m_slice);
  endtask

  typedef struct {
    logic           r;
    logic [N-1:0]   rq;
    logic [N-1:0]   dn;
    logic [DW-1:0]  dv;
    logic [N-1:0]   e_gnt;
    logic [IDW-1:0] e_id;
    logic           e_busy;
    logic           e_tick;
    logic [SW-1:0]  e_sl;
  } vec_t;

  vec_t tbl[15];
  int   ids[$];
  logic [N-1:0] prev_gnt;

  initial begin
    rst = 1'b1; req = '0; done = '0; div = '0;
    //          r  req      done     div  gnt      id  busy tick sl
    tbl[0]  = '{1, 4'b1111, 4'b0000, 4'd2, 4'b0000, 0, 0, 0, 0};
    tbl[1]  = '{1, 4'b1111, 4'b0000, 4'd2, 4'b0000, 0, 0, 0, 0};
    tbl[2]  = '{0, 4'b0001, 4'b0000, 4'd2, 4'b0001, 0, 1, 0, 0};
    tbl[3]  = '{0, 4'b0001, 4'b0000, 4'd7, 4'b0001, 0, 1, 0, 0};
    tbl[4]  = '{0, 4'b0001, 4'b0000, 4'd7, 4'b0001, 0, 1, 0, 0};
    tbl[5]  = '{0, 4'b0001, 4'b0000, 4'd7, 4'b0001, 0, 1, 1, 1};
    tbl[6]  = '{0, 4'b0001, 4'b0010, 4'd7, 4'b0001, 0, 1, 0, 1};
    tbl[7]  = '{0, 4'b0001, 4'b0001, 4'd7, 4'b0000, 0, 0, 0, 1};
    tbl[8]  = '{0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 0, 0, 0, 1};
    tbl[9]  = '{0, 4'b0010, 4'b0000, 4'd0, 4'b0010, 1, 1, 0, 0};
    tbl[10] = '{0, 4'b0010, 4'b0000, 4'd0, 4'b0010, 1, 1, 1, 1};
    tbl[11] = '{0, 4'b0010, 4'b0000, 4'd0, 4'b0010, 1, 1, 1, 2};
    tbl[12] = '{0, 4'b0010, 4'b0000, 4'd0, 4'b0010, 1, 1, 1, 3};
    tbl[13] = '{0, 4'b0010, 4'b0000, 4'd0, 4'b0000, 1, 0, 0, 3};
    tbl[14] = '{0, 4'b0011, 4'b0000, 4'd0, 4'b0001, 0, 1, 0, 0};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r, tbl[i].rq, tbl[i].dn, tbl[i].dv);
      chk($sformatf("vec%0d.gnt", i),  int'(gnt),       int'(tbl[i].e_gnt));
      chk($sformatf("vec%0d.id", i),   int'(gnt_id),    int'(tbl[i].e_id));
      chk($sformatf("vec%0d.busy", i), int'(busy),      int'(tbl[i].e_busy));
      chk($sformatf("vec%0d.tick", i), int'(tick),      int'(tbl[i].e_tick));
      chk($sformatf("vec%0d.sl", i),   int'(slice_cnt), int'(tbl[i].e_sl));
    end

    // Round robin from reset with all requesting and div=0
    cycle(1, 4'b1111, 4'b0000, 4'd0);
    prev_gnt = gnt;
    for (int c = 0; c < 27; c++) begin
      cycle(0, 4'b1111, 4'b0000, 4'd0);
      if (prev_gnt == 0 && gnt != 0) ids.push_back(int'(gnt_id));
      prev_gnt = gnt;
    end
    chk("rr.grants", ids.size() >= 5 ? 5 : ids.size(), 5);
    for (int k = 0; k < 5 && k < ids.size(); k++)
      chk($sformatf("rr.id%0d", k), ids[k], k % 4);

    // Reset mid-grant: requester 2 owns, reset at G+4, then requester 0 wins
    cycle(1, 4'b0000, 4'b0000, 4'd2);
    cycle(0, 4'b0100, 4'b0000, 4'd2);
    chk("mid.gnt_pre", int'(gnt), 4);
    for (int c = 0; c < 4; c++) cycle(0, 4'b0100, 4'b0000, 4'd2);
    cycle(1, 4'b0100, 4'b0100, 4'd2);
    chk("mid.gnt", int'(gnt), 0);
    chk("mid.id", int'(gnt_id), 0);
    chk("mid.sl", int'(slice_cnt), 0);
    chk("mid.tick", int'(tick), 0);
    cycle(0, 4'b0101, 4'b0000, 4'd2);
    chk("mid.regrant", int'(gnt), 1);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0]  rq, dn;
      logic [DW-1:0] dv;
      bit r;
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 9) == 0) ? N'($urandom) : (req | N'($urandom_range(0, 15) & $urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) rq = N'($urandom);
      dn = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
      dv = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) dv = DW'($urandom);
      cycle(r, rq, dn, dv);
      chk_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
